// File: rtl/stim_sweep_gen_if.sv
// rtl/stim_sweep_gen_if.sv - control, response and stimulus signals of the sweep generator
interface stim_sweep_gen_if #(
    parameter int VEC_W = 5,
    parameter int RSP_W = 6
) ();
    logic             start;
    logic             hold;
    logic [RSP_W-1:0] rsp;
    logic [VEC_W-1:0] vec;
    logic             vec_valid;
    logic             busy;
    logic             done;
    logic [RSP_W-1:0] sig;
    logic [VEC_W:0]   count;

    // master is the generator itself; slave is whoever controls it and returns rsp
    modport master (
        input  start, hold, rsp,
        output vec, vec_valid, busy, done, sig, count
    );

    modport slave (
        output start, hold, rsp,
        input  vec, vec_valid, busy, done, sig, count
    );
endinterface

// File: rtl/stim_sweep_gen.sv
// rtl/stim_sweep_gen.sv - exhaustive stimulus sweep with dwell, hold and rotate-xor response signature
module stim_sweep_gen #(
    parameter int VEC_W = 5,
    parameter int RSP_W = 6,
    parameter int DWELL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    stim_sweep_gen_if.master   bus
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [DW_W-1:0]   dwell_q, dwell_n;
    logic [VEC_W-1:0]  vec_q,   vec_n;
    logic [RSP_W-1:0]  sig_q,   sig_n;
    logic [VEC_W:0]    count_q, count_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            vec_q   <= '0;
            sig_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            dwell_q <= dwell_n;
            vec_q   <= vec_n;
            sig_q   <= sig_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n = state_q;
        dwell_n = dwell_q;
        vec_n   = vec_q;
        sig_n   = sig_q;
        count_n = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    dwell_n = '0;
                    vec_n   = '0;
                    sig_n   = '0;
                    count_n = '0;
                end
            end
            RUN: begin
                // hold freezes everything; rsp only matters on the last dwell cycle
                if (!bus.hold) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_n = '0;
                        sig_n   = {sig_q[RSP_W-2:0], sig_q[RSP_W-1]} ^ bus.rsp;
                        count_n = count_q + (VEC_W+1)'(1);
                        if (&vec_q) begin
                            state_n = DONE;
                        end else begin
                            vec_n = vec_q + VEC_W'(1);
                        end
                    end else begin
                        dwell_n = dwell_q + DW_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.vec       = vec_q;
    assign bus.vec_valid = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.sig       = sig_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_stim_sweep_gen.sv
// tb/tb_stim_sweep_gen.sv - self-checking bench for stim_sweep_gen
module tb_stim_sweep_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stim_sweep_gen_if #(.VEC_W(2), .RSP_W(4)) a_if ();
    stim_sweep_gen_if #(.VEC_W(2), .RSP_W(4)) b_if ();
    stim_sweep_gen_if #(.VEC_W(5), .RSP_W(6)) c_if ();

    stim_sweep_gen #(.VEC_W(2), .RSP_W(4), .DWELL(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    stim_sweep_gen #(.VEC_W(2), .RSP_W(4), .DWELL(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    stim_sweep_gen u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    assign c_if.rsp = {1'b0, c_if.vec};

    typedef struct {
        logic       start;
        logic       hold;
        logic [3:0] rsp;
        logic [1:0] vec;
        logic       valid;
        logic       busy;
        logic       done;
        logic [3:0] sig;
        logic [2:0] count;
    } row_t;

    row_t tbl[20];
    row_t sb[$];
    row_t exp_r;
    logic [1:0] exp_vec_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic s, input logic h, input logic [3:0] r, input logic [1:0] v,
                                input logic vl, input logic b, input logic d, input logic [3:0] sg,
                                input logic [2:0] c);
        row_t x;
        x.start = s; x.hold = h; x.rsp = r; x.vec = v; x.valid = vl;
        x.busy = b; x.done = d; x.sig = sg; x.count = c;
        return x;
    endfunction

    function automatic logic [5:0] c_model();
        logic [5:0] s = '0;
        for (int v = 0; v < 32; v++) s = {s[4:0], s[5]} ^ 6'(v);
        return s;
    endfunction

    initial begin
        //            st h  rsp   vec vl b  d  sig   cnt
        tbl[0]  = mk(1, 0, 4'h1, 0, 1, 1, 0, 4'h0, 0);
        tbl[1]  = mk(0, 0, 4'h1, 1, 1, 1, 0, 4'h1, 1);
        tbl[2]  = mk(1, 0, 4'h1, 2, 1, 1, 0, 4'h3, 2);
        tbl[3]  = mk(0, 0, 4'h1, 3, 1, 1, 0, 4'h7, 3);
        tbl[4]  = mk(0, 0, 4'h1, 3, 0, 0, 1, 4'hF, 4);
        tbl[5]  = mk(0, 0, 4'h1, 3, 0, 0, 1, 4'hF, 4);
        tbl[6]  = mk(1, 0, 4'h1, 0, 1, 1, 0, 4'h0, 0);
        tbl[7]  = mk(0, 0, 4'h1, 1, 1, 1, 0, 4'h1, 1);
        tbl[8]  = mk(0, 1, 4'hF, 1, 1, 1, 0, 4'h1, 1);
        tbl[9]  = mk(0, 1, 4'hF, 1, 1, 1, 0, 4'h1, 1);
        tbl[10] = mk(1, 1, 4'hF, 1, 1, 1, 0, 4'h1, 1);
        tbl[11] = mk(0, 1, 4'hF, 1, 1, 1, 0, 4'h1, 1);
        tbl[12] = mk(0, 1, 4'hF, 1, 1, 1, 0, 4'h1, 1);
        tbl[13] = mk(0, 0, 4'h1, 2, 1, 1, 0, 4'h3, 2);
        tbl[14] = mk(0, 0, 4'h1, 3, 1, 1, 0, 4'h7, 3);
        tbl[15] = mk(0, 0, 4'h1, 3, 0, 0, 1, 4'hF, 4);
        tbl[16] = mk(1, 1, 4'h1, 0, 1, 1, 0, 4'h0, 0);
        tbl[17] = mk(0, 1, 4'h1, 0, 1, 1, 0, 4'h0, 0);
        tbl[18] = mk(0, 0, 4'h1, 1, 1, 1, 0, 4'h1, 1);
        tbl[19] = mk(0, 0, 4'h1, 2, 1, 1, 0, 4'h3, 2);

        rst_n = 1'b0;
        a_if.start = 0; a_if.hold = 0; a_if.rsp = '0;
        b_if.start = 0; b_if.hold = 0; b_if.rsp = '0;
        c_if.start = 0; c_if.hold = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_busy", a_if.busy, 0);
        check("rst_a_done", a_if.done, 0);
        check("rst_a_vec", a_if.vec, 0);
        check("rst_b_valid", b_if.vec_valid, 0);
        check("rst_c_count", c_if.count, 0);
        check("rst_c_sig", c_if.sig, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // DWELL=1 sweeps: basic, start-while-busy, hold, restart, start+hold
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_if.start = tbl[i].start;
            a_if.hold  = tbl[i].hold;
            a_if.rsp   = tbl[i].rsp;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp_r = sb.pop_front();
            check($sformatf("row%0d_vec", i),   a_if.vec,       exp_r.vec);
            check($sformatf("row%0d_valid", i), a_if.vec_valid, exp_r.valid);
            check($sformatf("row%0d_busy", i),  a_if.busy,      exp_r.busy);
            check($sformatf("row%0d_done", i),  a_if.done,      exp_r.done);
            check($sformatf("row%0d_sig", i),   a_if.sig,       exp_r.sig);
            check($sformatf("row%0d_count", i), a_if.count,     exp_r.count);
        end

        // asynchronous reset mid-sweep at vec=2, observed before the next edge
        a_if.start = 0; a_if.hold = 0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", a_if.vec, 0);
        check("arst_valid", a_if.vec_valid, 0);
        check("arst_busy", a_if.busy, 0);
        check("arst_done", a_if.done, 0);
        check("arst_sig", a_if.sig, 0);
        check("arst_count", a_if.count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_idle%0d_busy", k), a_if.busy, 0);
            check($sformatf("post_rst_idle%0d_done", k), a_if.done, 0);
        end

        // start on the very first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        a_if.start = 1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_start_busy", a_if.busy, 1);
        check("first_edge_start_vec", a_if.vec, 0);
        a_if.start = 0;

        // DWELL=3: rsp is nonzero except on sample edges, so stray sampling corrupts sig
        for (int k = 0; k < 12; k++) exp_vec_q.push_back(2'(k / 3));
        @(negedge clk);
        b_if.start = 1;
        b_if.rsp = 4'hA;
        for (int k = 0; k < 13; k++) begin
            @(posedge clk);
            #1;
            b_if.start = 0;
            b_if.rsp = ((k + 1) % 3 == 0) ? 4'h0 : 4'hA;
            if (k < 12) begin
                check($sformatf("dw_c%0d_vec", k), b_if.vec, exp_vec_q.pop_front());
                check($sformatf("dw_c%0d_busy", k), b_if.busy, 1);
                check($sformatf("dw_c%0d_done", k), b_if.done, 0);
            end else begin
                check("dw_done", b_if.done, 1);
                check("dw_busy_end", b_if.busy, 0);
                check("dw_sig", b_if.sig, 0);
                check("dw_count", b_if.count, 4);
                check("dw_vec", b_if.vec, 3);
            end
        end

        // default parameters, rsp = {0,vec}
        @(negedge clk);
        c_if.start = 1;
        @(posedge clk);
        #1;
        c_if.start = 0;
        begin
            int ev = 0;
            for (int n = 0; n < 100; n++) begin
                if (c_if.done) break;
                check($sformatf("full_vec%0d", ev), c_if.vec, ev);
                ev++;
                @(posedge clk);
                #1;
            end
            check("full_swept", ev, 32);
        end
        check("full_done", c_if.done, 1);
        check("full_count", c_if.count, 32);
        check("full_vec_final", c_if.vec, 31);
        check("full_sig", c_if.sig, c_model());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stim_sweep_gen.md
STIM_SWEEP_GEN -- requirements
Module: stim_sweep_gen

Interface
REQ-001 Parameter VEC_W, default 5: stimulus vector width; the sweep covers 2^VEC_W vectors.
REQ-002 Parameter RSP_W, default 6: width of the DUT response and the signature, minimum 2.
REQ-003 Parameter DWELL, default 1: clock cycles each vector is held, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 hold  input  1  freezes sweep progress while high.
REQ-008 rsp  input  RSP_W  response from the downstream DUT for the current vector.
REQ-009 vec  output  VEC_W  stimulus vector driven to the DUT.
REQ-010 vec_valid  output  1  vec is a live sweep vector.
REQ-011 busy  output  1  sweep in progress.
REQ-012 done  output  1  sweep complete; sticky until the next accepted start or reset.
REQ-013 sig  output  RSP_W  response signature.
REQ-014 count  output  VEC_W+1  number of vectors sampled in the current or last sweep.

Function
REQ-015 The block SHALL implement three FSM states: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL move the FSM to RUN on that edge and set vec=0, dwell counter=0, sig=0, count=0 and done=0.
REQ-017 In RUN, start SHALL be ignored.
REQ-018 vec_valid and busy SHALL be 1 exactly while in RUN; the first vec_valid=1 occurs the cycle after start is sampled.
REQ-019 In RUN with hold=0, the dwell counter SHALL increment each cycle, from 0 to DWELL-1.
REQ-020 In RUN with hold=1, the dwell counter, vec, sig, count and state SHALL all hold, and no sample SHALL be taken.
REQ-021 The sample edge is RUN, hold=0 and dwell counter=DWELL-1. On it: sig <= rotate_left(sig,1) XOR rsp; count <= count+1; dwell counter <= 0.
REQ-022 On a sample edge with vec < 2^VEC_W-1, vec SHALL increment by 1.
REQ-023 On a sample edge with vec = all-ones, vec SHALL hold, the FSM SHALL go to DONE, and done SHALL be 1 from the next cycle.
REQ-024 vec SHALL never wrap within a sweep.
REQ-025 count SHALL reach exactly 2^VEC_W at DONE, with no overflow because it is VEC_W+1 bits wide.
REQ-026 Without hold, a sweep SHALL last exactly 2^VEC_W*DWELL RUN cycles; each hold cycle adds exactly one cycle.
REQ-027 In DONE: vec_valid=0, busy=0, done=1; vec, sig and count SHALL retain their final values.
REQ-028 start and hold high in the same cycle from IDLE or DONE: start SHALL be accepted; hold then applies from the first RUN cycle.
REQ-029 rsp SHALL be sampled only on sample edges; its value on all other cycles has no effect.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, vec=0, vec_valid=0, busy=0, done=0, sig=0, count=0 and dwell counter=0.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep; a new start is required after release.
REQ-032 The first clock edge after rst_n rises SHALL be able to accept start.

Verification
REQ-033 VEC_W=2, RSP_W=4, DWELL=1, rsp=4'h1, start pulse -> vec 0,1,2,3 on four consecutive cycles; then done=1, sig=4'hF, count=4, vec=3.
REQ-034 VEC_W=2, DWELL=3, rsp=0 -> each vec held 3 cycles; busy high for 12 cycles; done=1 on the 13th cycle after start; sig=0.
REQ-035 VEC_W=2, DWELL=1, hold=1 for 5 cycles while vec=1 -> vec stays 1 for 6 cycles; done is delayed by exactly 5 cycles; final sig and count match REQ-033.
REQ-036 Start pulses while busy=1 -> no effect. Start in DONE -> done drops the next cycle, vec=0, sig=0, count=0, and the sweep re-runs identically.
REQ-037 rst_n pulsed low asynchronously mid-sweep (vec=2) -> all outputs are 0 before the next clock edge; the FSM stays IDLE until start.
REQ-038 Default parameters, rsp tied to {1'b0,vec} -> 32 vectors swept, count=32, and sig matches the reference model of REQ-021.
